// File: rtl/sqrt_accel_param.sv
`default_nettype none
// ============================================================================
// sqrt_accel_param : bus-mapped restoring square-root unit, one root bit/cycle
// Optional REMAINDER register enabled by macro SQRT_ACCEL_REMAINDER_EN.
// Revision 1.0
// ============================================================================
module sqrt_accel_param #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int RW = WIDTH / 2;
  localparam int CW = (RW > 1) ? $clog2(RW) : 1;
  localparam int AW = RW + 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] radicand;
  logic [WIDTH-1:0] shift;
  logic [RW-1:0]    root;
  logic [RW-1:0]    q;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             done;
  logic             overrun;
`ifdef SQRT_ACCEL_REMAINDER_EN
  logic [RW:0]      remainder;
`endif

  logic busy, wr_radicand, wr_status, rd_root, start, last;

  assign busy        = (state == COMPUTE);
  assign wr_radicand = cs && we && (addr[3:2] == 2'b00);
  assign wr_status   = cs && we && (addr[3:2] == 2'b10);
  assign rd_root     = cs && !we && (addr[3:2] == 2'b01);
  assign start       = wr_radicand && (state == IDLE);
  assign last        = busy && (cnt == CW'(RW - 1));

  // Restoring step: bring down the next radicand pair, try subtracting 4q+1.
  logic [AW-1:0] acc_sh, trial, acc_next;
  logic [RW-1:0] q_next;

  always_comb begin
    acc_sh   = {acc[AW-3:0], shift[WIDTH-1:WIDTH-2]};
    trial    = {1'b0, q, 2'b01};
    acc_next = acc_sh;
    q_next   = {q[RW-2:0], 1'b0};
    if (acc_sh >= trial) begin
      acc_next = acc_sh - trial;
      q_next   = {q[RW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      radicand <= '0;
      shift    <= '0;
      root     <= '0;
      q        <= '0;
      acc      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (start) begin
        radicand <= wdata[WIDTH-1:0];
        shift    <= wdata[WIDTH-1:0];
        q        <= '0;
        acc      <= '0;
        cnt      <= '0;
      end else if (busy) begin
        shift <= {shift[WIDTH-3:0], 2'b00};
        acc   <= acc_next;
        q     <= q_next;
        cnt   <= cnt + CW'(1);
        if (last) root <= q_next;
      end

      // Completion wins over a same-edge ROOT read.
      if (start)        done <= 1'b0;
      else if (last)    done <= 1'b1;
      else if (rd_root) done <= 1'b0;

      if (wr_radicand && busy)         overrun <= 1'b1;
      else if (wr_status && wdata[2])  overrun <= 1'b0;
    end
  end

`ifdef SQRT_ACCEL_REMAINDER_EN
  always_ff @(posedge clk) begin
    if (reset)     remainder <= '0;
    else if (last) remainder <= acc_next[RW:0];
  end
`endif

  always_comb begin
    rdata = '0;
    if (cs && !we) begin
      case (addr[3:2])
        2'b00:   rdata = 32'(radicand);
        2'b01:   rdata = 32'(root);
        2'b10:   rdata = {29'b0, overrun, done, busy};
`ifdef SQRT_ACCEL_REMAINDER_EN
        2'b11:   rdata = 32'(remainder);
`else
        2'b11:   rdata = '0;
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign irq = done;

  // The two top accumulator bits never carry a remainder; undecoded bus bits.
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata, acc[AW-1:AW-2]};

endmodule
`default_nettype wire

// File: doc/sqrt_accel_param.md
SQRT_ACCEL_PARAM -- requirements
Module: sqrt_accel_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, radicand width in bits (even, 4..32).
REQ-002 SHALL derive localparam RW = WIDTH/2: root width and iteration count.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  chip select for bus access.
REQ-006 SHALL have port we  input  1  write enable; read when cs=1 and we=0.
REQ-007 SHALL have port addr  input  32  byte address; only addr[3:2] decoded.
REQ-008 SHALL have port wdata  input  32  write data; radicand taken from wdata[WIDTH-1:0].
REQ-009 SHALL have port rdata  output  32  combinational read data, zero-extended.
REQ-010 SHALL have port irq  output  1  level interrupt, equal to STATUS.done.

Function
REQ-011 SHALL decode the register map: 0x0 RADICAND (R/W), 0x4 ROOT (R), 0x8 STATUS (R/W), 0xC REMAINDER (R).
REQ-012 SHALL drive rdata = 0 whenever cs=0 or we=1.
REQ-013 SHALL define STATUS bits: bit0 busy, bit1 done, bit2 overrun; bits 31:3 read 0.
REQ-014 SHALL use FSM states IDLE and COMPUTE; busy = (state == COMPUTE).
REQ-015 SHALL, on an edge with cs & we & addr[3:2]=00 in IDLE: latch radicand, clear done, zero accumulators, enter COMPUTE.
REQ-016 SHALL compute with the restoring digit-by-digit method, one root bit per cycle, exactly RW cycles in COMPUTE.
REQ-017 SHALL, on the RW-th COMPUTE edge: load ROOT (RW bits) and REMAINDER (RW+1 bits), set done, return to IDLE.
REQ-018 SHALL make results readable RW cycles after the start edge (16 for WIDTH=32); busy is 1 for exactly RW cycles.
REQ-019 SHALL guarantee ROOT = floor(sqrt(radicand)) and REMAINDER = radicand - ROOT^2 for every radicand, including 0 and all-ones.
REQ-020 SHALL ignore a RADICAND write while busy (radicand and computation unchanged) and set overrun.
REQ-021 SHALL clear done on the edge of a read of ROOT (cs & !we & addr[3:2]=01).
REQ-022 SHALL give set priority: if done is set and a ROOT read occurs on the same edge, done ends at 1.
REQ-023 SHALL clear overrun on a write to STATUS with wdata[2]=1; other STATUS bits are not writable.
REQ-024 SHALL keep ROOT and REMAINDER unchanged until the next computation completes.
REQ-025 SHALL ignore writes to 0x4 and 0xC.

Reset
REQ-026 SHALL, when reset=1 at a clock edge, go to IDLE and clear radicand, ROOT, REMAINDER, busy, done, overrun, all datapath registers.
REQ-027 SHALL abort any computation in progress on reset, with no done or result update afterwards.
REQ-028 SHALL give reset priority over any bus access on the same edge.
REQ-029 SHALL force rdata = 0 and irq = 0 in the cycle after reset.

Configuration
REQ-030 SHALL gate the remainder feature with macro SQRT_ACCEL_REMAINDER_EN.
REQ-031 SHALL, when SQRT_ACCEL_REMAINDER_EN is defined, implement the REMAINDER register and return it at 0xC.
REQ-032 SHALL, when SQRT_ACCEL_REMAINDER_EN is undefined, omit the register and return 0 at 0xC; all other behaviour is unchanged.

Verification
REQ-033 SHALL check WIDTH=32: write 0x0000_0010 to 0x0 -> busy for 16 cycles, then ROOT=4, REMAINDER=0, done=1, irq=1.
REQ-034 SHALL check WIDTH=32: write 0xFFFF_FFFF -> ROOT=0x0000_FFFF, REMAINDER=0x0001_FFFE; write 0 -> ROOT=0, REMAINDER=0.
REQ-035 SHALL check WIDTH=8: write 200 -> 4 busy cycles, ROOT=14, REMAINDER=4; wdata[31:8] ignored.
REQ-036 SHALL check a write of 100 followed 3 cycles later by a write of 9 -> ROOT=10, STATUS=0x6; after STATUS write 0x4 -> STATUS=0x2; after ROOT read -> STATUS=0x0, irq=0.
REQ-037 SHALL check reset asserted 5 cycles into a computation -> STATUS=0, ROOT=0, and no done or irq in the 20 cycles after reset.
REQ-038 SHALL check a build without SQRT_ACCEL_REMAINDER_EN: write 0x0000_0011 -> ROOT=4, read at 0xC returns 0.
